rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register-file word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register-file address width (2**ADDR_W entries).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports REQ0_VALID (input, 1), REQ0_ADDR (input, ADDR_W), REQ0_DATA (input, DATA_W) and REQ0_READY (output, 1): requester 0 write channel.
REQ-006 The block SHALL have ports REQ1_VALID (input, 1), REQ1_ADDR (input, ADDR_W), REQ1_DATA (input, DATA_W) and REQ1_READY (output, 1): requester 1 write channel.
REQ-007 The block SHALL have port CLR, input, 1 bit: a request to re-zero the whole register file.
REQ-008 The block SHALL have ports RF_WE (output, 1), RF_RW (output, ADDR_W) and RF_DW (output, DATA_W), driving the 2R1W register-file write port.
REQ-009 The block SHALL have port INIT_DONE, output, 1 bit: high while the register file holds valid contents and writes are being accepted.

Function
REQ-010 The block SHALL implement states INIT and RUN.
REQ-011 After reset the block SHALL be in INIT with the init counter at 0.
REQ-012 On each edge in INIT the block SHALL register RF_WE=1, RF_RW=counter and RF_DW=0, then increment the counter.
REQ-013 In INIT, when the counter equals 2**ADDR_W-1, the block SHALL issue the final init write and move to RUN on the same edge.
REQ-014 INIT SHALL last exactly 2**ADDR_W cycles; the last init write (address 2**ADDR_W-1) is on the port during the first RUN cycle.
REQ-015 INIT_DONE SHALL be a registered output equal to 1 exactly when the state is RUN.
REQ-016 REQ0_READY and REQ1_READY SHALL be 0 in INIT and in any cycle where CLR=1.
REQ-017 In RUN with CLR=0, READY SHALL follow round-robin: with a single valid requester, only that requester is ready; with both valid, only the requester selected by the priority pointer is ready.
REQ-018 At most one READY SHALL be high in any cycle.
REQ-019 A handshake (VALID and READY both high at an edge) SHALL register RF_WE=1 and that requester's ADDR/DATA onto RF_RW/RF_DW: exactly 1 cycle latency, with the memory updated at the following edge.
REQ-020 With no handshake in RUN, RF_WE SHALL be registered 0 and RF_RW/RF_DW SHALL hold their previous values.
REQ-021 After a grant the priority pointer SHALL point to the other requester.
REQ-022 The priority pointer SHALL NOT change on cycles without a grant.
REQ-023 Sustained both-valid traffic SHALL alternate 0,1,0,1 at one write per cycle.
REQ-024 When CLR=1 in RUN, the block SHALL enter INIT at the next edge with the counter at 0.
REQ-025 A write registered on the edge before CLR SHALL still reach the port; no handshake SHALL occur in the CLR cycle.
REQ-026 CLR during INIT SHALL be ignored, with no counter restart.
REQ-027 Writes to the same address from both requesters in consecutive cycles SHALL land in grant order, last writer wins.
REQ-028 VALID SHALL be sampled only together with READY; the block places no stability requirement on a non-granted requester.

Reset
REQ-029 Asserting RESETn=0 SHALL immediately force RF_WE=0, RF_RW=0, RF_DW=0, INIT_DONE=0, both READY=0, state=INIT, counter=0 and priority pointer=0 (requester 0 first).
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abandon all activity; after release the full INIT sequence SHALL restart from address 0.
REQ-031 The first init write SHALL appear one cycle after RESETn is released.

Structure
REQ-032 The state encoding (INIT/RUN) and the width of the 2-requester pointer SHALL live in a shared package/include, rf_ctrl_pkg, reused by later register-file controllers.
REQ-033 The round-robin selection SHALL be a sub-module, rr_arb2 (inputs: two valids and the pointer; outputs: one-hot grant).
REQ-034 The top level SHALL hold the FSM, counter, pointer and output registers.

Verification
REQ-035 Reset release, no traffic: RF_WE=1 for 32 cycles with RF_RW=0..31 and RF_DW=0, then RF_WE=0; INIT_DONE rises in the cycle RF_RW=31 is shown; READY=0 throughout INIT.
REQ-036 RUN, both requesters continuously valid (REQ0 addr 3/data 0xA, REQ1 addr 7/data 0xB): grants alternate 0,1,0,...; RF_RW sequence 3,7,3,7 one cycle after each grant.
REQ-037 RUN, only REQ1 valid for 3 cycles, then both valid: REQ1 is granted 3 times, then the pointer gives REQ0 the first both-valid grant.
REQ-038 CLR pulse in the same cycle as REQ0 valid, with the previous cycle's grant being REQ1 addr 5: no READY in the CLR cycle; RF_WE for addr 5 appears; next edge starts a 32-cycle INIT; REQ0 is accepted only after INIT_DONE.
REQ-039 RESETn pulsed low while the init counter is at 17: outputs drop to reset values asynchronously; after release, INIT restarts at address 0 and runs a full 32 cycles.
REQ-040 REQ0 writes addr 9=0x1 then REQ1 writes addr 9=0x2 on back-to-back grants: the register-file read of addr 9 returns 0x2 after both writes land.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file controllers: FSM encoding and
// the two-requester round-robin pointer.
package rf_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam int RR_PTR_W = 1;
    typedef logic [RR_PTR_W-1:0] rr_ptr_t;

    // After requester idx is granted, priority passes to the other one.
    function automatic rr_ptr_t rr_other(input rr_ptr_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector: a lone requester always wins, a tie
// goes to the requester the pointer names. Grant is one-hot or zero.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  rr_ptr_t    ptr_i,
    output logic [1:0] gnt_o
);

    // pick requester 0 unless it is absent or loses the tie
    always_comb begin
        gnt_o = 2'b00;
        if (valid0_i && (!valid1_i || ptr_i == rr_ptr_t'(0))) begin
            gnt_o = 2'b01;
        end else if (valid1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for a 2R1W register file. After reset or CLR it
// zeroes every entry (INIT), then arbitrates two write requesters
// round-robin (RUN). All write-port outputs are registered.
module rf_wr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    input  logic              CLR,
    output logic              RF_WE,
    output logic [ADDR_W-1:0] RF_RW,
    output logic [DATA_W-1:0] RF_DW,
    output logic              INIT_DONE
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    rr_ptr_t           ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] dw_q, dw_d;
    logic              done_q, done_d;
    logic              arb_en;
    logic [1:0]        gnt;

    // Requests are only visible to the arbiter in RUN and outside a CLR cycle,
    // so READY can never rise while the file is being re-zeroed.
    assign arb_en = (state_q == ST_RUN) && !CLR;

    rr_arb2 u_arb (
        .valid0_i (REQ0_VALID && arb_en),
        .valid1_i (REQ1_VALID && arb_en),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign RF_WE      = we_q;
    assign RF_RW      = rw_q;
    assign RF_DW      = dw_q;
    assign INIT_DONE  = done_q;

    // state register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    // next state: INIT ends with its final write, CLR in RUN restarts INIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == CNT_LAST) state_d = ST_RUN;
            ST_RUN:  if (CLR)               state_d = ST_INIT;
            default:                        state_d = ST_INIT;
        endcase
    end

    // outputs: init sweep, granted write, or idle hold of address/data
    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        rw_d   = rw_q;
        dw_d   = dw_q;
        done_d = (state_d == ST_RUN);
        case (state_q)
            ST_INIT: begin
                we_d  = 1'b1;
                rw_d  = cnt_q;
                dw_d  = '0;
                cnt_d = cnt_q + 1'b1;
            end
            ST_RUN: begin
                cnt_d = '0;
                if (gnt[0]) begin
                    we_d = 1'b1;
                    rw_d = REQ0_ADDR;
                    dw_d = REQ0_DATA;
                end else if (gnt[1]) begin
                    we_d = 1'b1;
                    rw_d = REQ1_ADDR;
                    dw_d = REQ1_DATA;
                end
                if (|gnt) ptr_d = rr_other(rr_ptr_t'(gnt[1]));
            end
            default: cnt_d = '0;
        endcase
    end

    // counter, pointer and write-port registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q  <= '0;
            ptr_q  <= '0;
            we_q   <= 1'b0;
            rw_q   <= '0;
            dw_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            rw_q   <= rw_d;
            dw_q   <= dw_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a driver advances a rule-level model
// each cycle and queues the expected write-port contents; a monitor pops
// and compares after every rising edge. A memory on the write port stands
// in for the register file and is compared to the model's memory at the end.
module tb_rf_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NENT = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0, CLR = 1'b0;
    logic [AW-1:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic [DW-1:0] REQ0_DATA = '0, REQ1_DATA = '0;
    logic          REQ0_READY, REQ1_READY, RF_WE, INIT_DONE;
    logic [AW-1:0] RF_RW;
    logic [DW-1:0] RF_DW;

    rf_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .CLR(CLR), .RF_WE(RF_WE), .RF_RW(RF_RW), .RF_DW(RF_DW), .INIT_DONE(INIT_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            we;
        logic [AW-1:0] rw;
        logic [DW-1:0] dw;
        bit            done;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail = 0;

    // reference model: "initialising, next address to zero" or "running",
    // which requester wins a tie, what the port last showed, expected memory
    bit            m_init = 1'b1;
    int            m_iaddr = 0;
    int            m_tie = 0;
    logic [AW-1:0] m_last_rw = '0;
    logic [DW-1:0] m_last_dw = '0;
    logic [DW-1:0] ref_mem[NENT];
    logic [DW-1:0] rf_mem[NENT];

    // the register file the write port drives
    always @(posedge CLK) if (RF_WE) rf_mem[RF_RW] <= RF_DW;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1; m_iaddr = 0; m_tie = 0; m_last_rw = '0; m_last_dw = '0;
    endtask

    // one cycle of stimulus; queues what the port must show after the edge
    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit clr);
        int   g;
        exp_t e;
        @(negedge CLK);
        REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
        REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
        CLR = clr;
        #1;
        g = -1;
        if (m_init) begin
            e.we = 1'b1; e.rw = AW'(m_iaddr); e.dw = '0;
            ref_mem[m_iaddr] = '0;
            m_iaddr++;
            if (m_iaddr == NENT) m_init = 1'b0;
            e.done = !m_init;
        end else if (clr) begin
            e.we = 1'b0; e.rw = m_last_rw; e.dw = m_last_dw; e.done = 1'b0;
            m_init = 1'b1; m_iaddr = 0;
        end else begin
            if (v0 && v1) g = m_tie;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
            e.done = 1'b1;
            if (g == 0) begin
                e.we = 1'b1; e.rw = a0; e.dw = d0;
            end else if (g == 1) begin
                e.we = 1'b1; e.rw = a1; e.dw = d1;
            end else begin
                e.we = 1'b0; e.rw = m_last_rw; e.dw = m_last_dw;
            end
            if (g >= 0) begin
                ref_mem[e.rw] = e.dw;
                m_tie = 1 - g;
            end
        end
        m_last_rw = e.rw; m_last_dw = e.dw;
        chk("ready0", 64'(REQ0_READY), 64'(g == 0));
        chk("ready1", 64'(REQ1_READY), 64'(g == 1));
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_we"},   64'(RF_WE), 64'd0);
        chk({nm, "_rw"},   64'(RF_RW), 64'd0);
        chk({nm, "_dw"},   64'(RF_DW), 64'd0);
        chk({nm, "_done"}, 64'(INIT_DONE), 64'd0);
        chk({nm, "_rdy0"}, 64'(REQ0_READY), 64'd0);
        chk({nm, "_rdy1"}, 64'(REQ1_READY), 64'd0);
    endtask

    // reset asserted between edges; outputs must drop before any clock
    task automatic async_reset();
        @(negedge CLK);
        #3 RESETn = 1'b0;
        #1;
        sb.delete();
        chk_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge CLK);
        #2 RESETn = 1'b1;
    endtask

    // monitor: compare the write port after every edge that has an expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rf_we",     64'(RF_WE), 64'(e.we));
                chk("rf_rw",     64'(RF_RW), 64'(e.rw));
                chk("rf_dw",     64'(RF_DW), 64'(e.dw));
                chk("init_done", 64'(INIT_DONE), 64'(e.done));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NENT; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 chk_reset_outputs("rst");
        @(posedge CLK);
        #2 RESETn = 1'b1;

        // full init sweep then quiet port
        idle(NENT + 2);

        // both requesters valid: strict alternation
        for (int i = 0; i < 8; i++) step(1, 5'd3, 32'hA, 1, 5'd7, 32'hB, 0);

        // REQ1 alone three times, then a tie goes to REQ0
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1, 5'd2, 32'hC, 0);
        for (int i = 0; i < 2; i++) step(1, 5'd1, 32'hD, 1, 5'd2, 32'hE, 0);

        // same address from both requesters back to back: last writer wins
        step(1, 5'd9, 32'h1, 0, 5'd0, 32'h0, 0);
        step(0, 5'd0, 32'h0, 1, 5'd9, 32'h2, 0);
        idle(2);
        chk("rf9_last_writer", 64'(rf_mem[9]), 64'h2);

        // CLR right after a REQ1 grant, REQ0 waiting; CLR again mid-INIT
        step(0, 5'd0, 32'h0, 1, 5'd5, 32'h55, 0);
        step(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1);
        for (int i = 0; i < NENT + 3; i++)
            step(1, 5'd4, 32'h44, 0, 5'd0, 32'h0, (i == 10 || i == 11));

        // reset with the init counter at 17, then a clean full INIT
        async_reset();
        idle(17);
        async_reset();
        idle(NENT + 1);

        // randomized traffic with occasional CLR
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 39) == 0));

        // drain and compare register-file contents
        idle(NENT + 2);
        repeat (2) @(posedge CLK);
        #2;
        for (int i = 0; i < NENT; i++) chk($sformatf("mem[%0d]", i), 64'(rf_mem[i]), 64'(ref_mem[i]));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
